rpn_stack_exec: RTL and testbench

- Operand stack and executor for the 8-bit RPN ALU.
- The step sequencer writes (pushes) operands. This block is the reading end: it pops operands, applies the operator, and pushes the result back.
- TOP drives the display/LED path.

---
 rtl/rpn_stack_exec.sv | 200 ++++++++++++++++++++
 tb/tb_rpn_stack_exec.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_exec.sv
// Purpose : operand stack + executor for the 8-bit RPN ALU; pops B then A, computes A op B, pushes result.
// Latency : PUSH visible on TOP next cycle; binary op BUSY 4 cycles, NOT BUSY 3 cycles, DONE in the following cycle.
// Backpr. : no handshake; PUSH/EXEC while BUSY are dropped silently, full/empty/illegal requests set sticky ERR.
//
// Ports   : CLOCK/RESET (async active-low), CLEAR (sync flush), PUSH+DATA_IN, EXEC+OPCODE in;
//           TOP, COUNT, BUSY, DONE, CARRY, ZERO, ERR out.
// Macro   : RPN_MUL_EN builds the multiplier for OPCODE 111; without it that opcode is rejected with ERR.
module rpn_stack_exec #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              CLEAR,
    input  logic              PUSH,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              EXEC,
    input  logic [2:0]        OPCODE,
    output logic [DATA_W-1:0] TOP,
    output logic [CNT_W-1:0]  COUNT,
    output logic              BUSY,
    output logic              DONE,
    output logic              CARRY,
    output logic              ZERO,
    output logic              ERR
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [2:0] {S_IDLE, S_POP_B, S_POP_A, S_CALC, S_PUSH_R} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
    logic               carry_q, carry_d, zero_q, zero_d, err_q, err_d, done_q, done_d;

    // idx_push is the next free slot; idx_top wraps to DEPTH-1 when the stack is full.
    logic [IDX_W-1:0]   idx_push, idx_top;
    logic [CNT_W-1:0]   need;
    logic               illegal_op;

    logic [DATA_W-1:0]  calc_res;
    logic               calc_carry;
    logic [DATA_W:0]    sum_w;
    logic [2*DATA_W-1:0] shl_w;
`ifdef RPN_MUL_EN
    logic [2*DATA_W-1:0] mul_w;
`endif

    assign idx_push = count_q[IDX_W-1:0];
    assign idx_top  = idx_push - IDX_W'(1);
    assign need     = (OPCODE == OP_NOT) ? CNT_W'(1) : CNT_W'(2);
`ifdef RPN_MUL_EN
    assign illegal_op = 1'b0;
`else
    assign illegal_op = (OPCODE == OP_MUL);
`endif

    // Datapath for the CALC state; operands are already latched in a_q/b_q.
    always_comb begin
        sum_w      = {1'b0, a_q} + {1'b0, b_q};
        // Widened shift keeps the last bit pushed out at position DATA_W.
        shl_w      = {{DATA_W{1'b0}}, a_q} << b_q[2:0];
`ifdef RPN_MUL_EN
        mul_w      = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
`endif
        calc_res   = '0;
        calc_carry = 1'b0;
        case (op_q)
            OP_ADD: begin calc_res = sum_w[DATA_W-1:0]; calc_carry = sum_w[DATA_W]; end
            OP_SUB: begin calc_res = a_q - b_q;         calc_carry = (a_q < b_q);   end
            OP_AND: calc_res = a_q & b_q;
            OP_OR:  calc_res = a_q | b_q;
            OP_XOR: calc_res = a_q ^ b_q;
            OP_NOT: calc_res = ~b_q;
            OP_SHL: begin calc_res = shl_w[DATA_W-1:0]; calc_carry = shl_w[DATA_W]; end
`ifdef RPN_MUL_EN
            OP_MUL: begin calc_res = mul_w[DATA_W-1:0]; calc_carry = |mul_w[2*DATA_W-1:DATA_W]; end
`endif
            default: begin calc_res = '0; calc_carry = 1'b0; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        count_d = count_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
        done_d  = 1'b0;

        if (CLEAR) begin
            state_d = S_IDLE;
            count_d = '0;
            carry_d = 1'b0;
            zero_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // EXEC wins over a coincident PUSH, even when EXEC itself is rejected.
                    if (EXEC) begin
                        if (illegal_op || (count_q < need)) begin
                            err_d = 1'b1;
                        end else begin
                            op_d    = OPCODE;
                            state_d = S_POP_B;
                        end
                    end else if (PUSH) begin
                        if (count_q == FULL) begin
                            err_d = 1'b1;
                        end else begin
                            mem_d[idx_push] = DATA_IN;
                            count_d         = count_q + CNT_W'(1);
                        end
                    end
                end
                S_POP_B: begin
                    b_d     = mem_q[idx_top];
                    count_d = count_q - CNT_W'(1);
                    state_d = (op_q == OP_NOT) ? S_CALC : S_POP_A;
                end
                S_POP_A: begin
                    a_d     = mem_q[idx_top];
                    count_d = count_q - CNT_W'(1);
                    state_d = S_CALC;
                end
                S_CALC: begin
                    res_d   = calc_res;
                    carry_d = calc_carry;
                    zero_d  = (calc_res == '0);
                    state_d = S_PUSH_R;
                end
                S_PUSH_R: begin
                    mem_d[idx_push] = res_q;
                    count_d         = count_q + CNT_W'(1);
                    done_d          = 1'b1;
                    state_d         = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign TOP   = (count_q == '0) ? '0 : mem_q[idx_top];
    assign COUNT = count_q;
    assign BUSY  = (state_q != S_IDLE);
    assign DONE  = done_q;
    assign CARRY = carry_q;
    assign ZERO  = zero_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_rpn_stack_exec.sv
// Purpose : self-checking bench for rpn_stack_exec with a queue of expected op results.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpr. : waits on DONE are bounded to 20 cycles; a missing DONE counts as a failure.
module tb_rpn_stack_exec;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic              CLOCK = 1'b0;
    logic              RESET;
    logic              CLEAR;
    logic              PUSH;
    logic [DATA_W-1:0] DATA_IN;
    logic              EXEC;
    logic [2:0]        OPCODE;
    logic [DATA_W-1:0] TOP;
    logic [CNT_W-1:0]  COUNT;
    logic              BUSY, DONE, CARRY, ZERO, ERR;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DATA_W-1:0] top;
        logic              carry;
        logic              zero;
        logic [CNT_W-1:0]  count;
    } exp_t;

    exp_t sb_q[$];

    always #5 CLOCK = ~CLOCK;

    rpn_stack_exec #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .CLEAR(CLEAR), .PUSH(PUSH), .DATA_IN(DATA_IN),
        .EXEC(EXEC), .OPCODE(OPCODE), .TOP(TOP), .COUNT(COUNT), .BUSY(BUSY),
        .DONE(DONE), .CARRY(CARRY), .ZERO(ZERO), .ERR(ERR)
    );

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_push(input logic [DATA_W-1:0] v);
        PUSH = 1'b1; DATA_IN = v;
        step();
        PUSH = 1'b0;
    endtask

    task automatic do_clear();
        CLEAR = 1'b1;
        step();
        CLEAR = 1'b0;
    endtask

    // Issues one EXEC and waits (bounded) for DONE, counting BUSY cycles on the way.
    task automatic run_op(input logic [2:0] op, input bit push_same, input bit push_busy,
                          output int busy_cyc, output bit done_seen);
        EXEC = 1'b1; OPCODE = op;
        if (push_same) begin PUSH = 1'b1; DATA_IN = 8'h99; end
        step();
        EXEC = 1'b0; PUSH = 1'b0;
        busy_cyc  = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (DONE) begin done_seen = 1'b1; break; end
            if (BUSY) busy_cyc++;
            if (push_busy && i == 1) begin PUSH = 1'b1; DATA_IN = 8'h77; end
            step();
            PUSH = 1'b0;
        end
    endtask

    task automatic test_reset();
        exp_t obs;
        #1;
        checks++;
        if ({TOP, COUNT, BUSY, DONE, CARRY, ZERO, ERR} !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h want 0", {TOP, COUNT, BUSY, DONE, CARRY, ZERO, ERR});
        end
        step(); step();
        RESET = 1'b1;
        step();
        do_push(8'h11);
        do_push(8'h22);
        EXEC = 1'b1; OPCODE = OP_ADD;
        step();
        EXEC = 1'b0;
        step();
        // Now in POP_A: drop reset asynchronously, outputs must clear without an edge.
        RESET = 1'b0;
        #1;
        checks++;
        if ({TOP, COUNT, BUSY, DONE, CARRY, ZERO, ERR} !== '0) begin
            failures++;
            $display("FAIL reset_mid_op: got %h want 0", {TOP, COUNT, BUSY, DONE, CARRY, ZERO, ERR});
        end
        step();
        RESET = 1'b1;
        step();
        do_push(8'h05);
        obs = {TOP, CARRY, ZERO, COUNT};
        checks++;
        if (obs !== {8'h05, 1'b0, 1'b0, 3'd1}) begin
            failures++;
            $display("FAIL push_after_reset: got %h want %h", obs, {8'h05, 1'b0, 1'b0, 3'd1});
        end
    endtask

    task automatic test_add();
        int busy; bit done; exp_t e;
        do_clear();
        do_push(8'hF0);
        do_push(8'h20);
        sb_q.push_back('{top: 8'h10, carry: 1'b1, zero: 1'b0, count: 3'd1});
        run_op(OP_ADD, 1'b0, 1'b0, busy, done);
        checks++;
        if (!done) begin failures++; $display("FAIL add_done: got 0 want 1 (timeout)"); end
        checks++;
        if (busy !== 4) begin failures++; $display("FAIL add_busy: got %0d want 4", busy); end
        e = sb_q.pop_front();
        checks++;
        if ({TOP, CARRY, ZERO, COUNT} !== e) begin
            failures++; $display("FAIL add_result: got %h want %h", {TOP, CARRY, ZERO, COUNT}, e);
        end
        step();
        checks++;
        if (DONE !== 1'b0) begin failures++; $display("FAIL add_done_pulse: got %b want 0", DONE); end
    endtask

    task automatic test_sub();
        int busy; bit done; exp_t e;
        do_clear();
        do_push(8'h03);
        do_push(8'h05);
        sb_q.push_back('{top: 8'hFE, carry: 1'b1, zero: 1'b0, count: 3'd1});
        run_op(OP_SUB, 1'b0, 1'b0, busy, done);
        e = sb_q.pop_front();
        checks++;
        if (!done || {TOP, CARRY, ZERO, COUNT} !== e) begin
            failures++; $display("FAIL sub_borrow: got %h done %b want %h", {TOP, CARRY, ZERO, COUNT}, done, e);
        end
        do_push(8'hFE);
        sb_q.push_back('{top: 8'h00, carry: 1'b0, zero: 1'b1, count: 3'd1});
        run_op(OP_SUB, 1'b0, 1'b0, busy, done);
        e = sb_q.pop_front();
        checks++;
        if (!done || {TOP, CARRY, ZERO, COUNT} !== e) begin
            failures++; $display("FAIL sub_zero: got %h done %b want %h", {TOP, CARRY, ZERO, COUNT}, done, e);
        end
    endtask

    task automatic test_shl_logic();
        int busy; bit done; exp_t e;
        logic [2:0] ops [4] = '{OP_SHL, OP_XOR, OP_OR, OP_AND};
        logic [7:0] opnd [4] = '{8'h03, 8'h0F, 8'hF0, 8'h0F};
        do_clear();
        do_push(8'hA5);
        // 0xA5<<3 = 0x528: low byte 0x28, last bit out = bit 5 of 0xA5 = 1.
        sb_q.push_back('{top: 8'h28, carry: 1'b1, zero: 1'b0, count: 3'd1});
        sb_q.push_back('{top: 8'h27, carry: 1'b0, zero: 1'b0, count: 3'd1});
        sb_q.push_back('{top: 8'hF7, carry: 1'b0, zero: 1'b0, count: 3'd1});
        sb_q.push_back('{top: 8'h07, carry: 1'b0, zero: 1'b0, count: 3'd1});
        for (int i = 0; i < 4; i++) begin
            do_push(opnd[i]);
            run_op(ops[i], 1'b0, 1'b0, busy, done);
            e = sb_q.pop_front();
            checks++;
            if (!done || {TOP, CARRY, ZERO, COUNT} !== e) begin
                failures++;
                $display("FAIL logic_op%0d: got %h done %b want %h", i, {TOP, CARRY, ZERO, COUNT}, done, e);
            end
        end
    endtask

    task automatic test_errors();
        int busy; bit done;
        do_clear();
        for (int i = 1; i <= 5; i++) do_push(8'(i));
        checks++;
        if ({TOP, COUNT, ERR} !== {8'h04, 3'd4, 1'b1}) begin
            failures++; $display("FAIL overflow: got %h want %h", {TOP, COUNT, ERR}, {8'h04, 3'd4, 1'b1});
        end
        do_clear();
        checks++;
        if ({COUNT, ERR} !== {3'd0, 1'b0}) begin
            failures++; $display("FAIL clear: got %h want 0", {COUNT, ERR});
        end
        do_push(8'h07);
        run_op(OP_ADD, 1'b0, 1'b0, busy, done);
        checks++;
        if ({done, busy != 0, ERR, COUNT, TOP} !== {1'b0, 1'b0, 1'b1, 3'd1, 8'h07}) begin
            failures++;
            $display("FAIL underflow: got done %b busy %0d err %b count %0d top %h want 0 0 1 1 07",
                     done, busy, ERR, COUNT, TOP);
        end
    endtask

    task automatic test_ignored();
        int busy; bit done; exp_t e;
        do_clear();
        do_push(8'h5A);
        sb_q.push_back('{top: 8'hA5, carry: 1'b0, zero: 1'b0, count: 3'd1});
        run_op(OP_NOT, 1'b0, 1'b1, busy, done);
        checks++;
        if (busy !== 3) begin failures++; $display("FAIL not_busy: got %0d want 3", busy); end
        e = sb_q.pop_front();
        checks++;
        if (!done || {TOP, CARRY, ZERO, COUNT} !== e || ERR !== 1'b0) begin
            failures++;
            $display("FAIL not_push_busy: got %h err %b done %b want %h err 0", {TOP, CARRY, ZERO, COUNT}, ERR, done, e);
        end
        do_clear();
        do_push(8'h03);
        do_push(8'h04);
        sb_q.push_back('{top: 8'h07, carry: 1'b0, zero: 1'b0, count: 3'd1});
        run_op(OP_ADD, 1'b1, 1'b0, busy, done);
        e = sb_q.pop_front();
        checks++;
        if (!done || busy !== 4 || {TOP, CARRY, ZERO, COUNT} !== e) begin
            failures++;
            $display("FAIL push_with_exec: got %h busy %0d done %b want %h busy 4", {TOP, CARRY, ZERO, COUNT}, busy, done, e);
        end
    endtask

    task automatic test_mul();
        int busy; bit done;
        do_clear();
        do_push(8'h10);
        do_push(8'h20);
`ifdef RPN_MUL_EN
        begin
            exp_t e;
            sb_q.push_back('{top: 8'h00, carry: 1'b1, zero: 1'b1, count: 3'd1});
            run_op(OP_MUL, 1'b0, 1'b0, busy, done);
            e = sb_q.pop_front();
            checks++;
            if (!done || busy !== 4 || {TOP, CARRY, ZERO, COUNT} !== e) begin
                failures++;
                $display("FAIL mul: got %h busy %0d done %b want %h busy 4", {TOP, CARRY, ZERO, COUNT}, busy, done, e);
            end
        end
`else
        run_op(OP_MUL, 1'b0, 1'b0, busy, done);
        checks++;
        if ({done, busy != 0, ERR, COUNT, TOP} !== {1'b0, 1'b0, 1'b1, 3'd2, 8'h20}) begin
            failures++;
            $display("FAIL mul_disabled: got done %b busy %0d err %b count %0d top %h want 0 0 1 2 20",
                     done, busy, ERR, COUNT, TOP);
        end
`endif
    endtask

    initial begin
        RESET = 1'b0; CLEAR = 1'b0; PUSH = 1'b0; EXEC = 1'b0;
        DATA_IN = '0; OPCODE = '0;
        test_reset();
        test_add();
        test_sub();
        test_shl_logic();
        test_errors();
        test_ignored();
        test_mul();
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
